// File: rtl/hex_display_scanner.sv
// Double-buffered multi-digit hex scanner: drives one shared nibble bus plus one-hot digit enables,
// inserting a dark gap before every digit. Define HEX_SCAN_LEADING_ZERO_BLANK_EN to darken leading zeros.
module hex_display_scanner #(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [3:0]          hex,
    output logic                blank,
    output logic [DIGITS-1:0]   digit_en,
    output logic                frame_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int DATA_W  = 4 * DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [DATA_W-1:0] pending_q, pending_d;
    logic              pending_full_q, pending_full_d;
    logic [DATA_W-1:0] display_q, display_d;
    logic              frame_done_q, frame_done_d;

    logic              accept;
    logic              swap;
    logic [3:0]        nibble;
    logic              lz_dark;

    assign accept     = data_valid && !pending_full_q;
    assign data_ready = !pending_full_q;
    assign frame_done = frame_done_q;

    // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        counter_d      = counter_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        display_d      = display_q;
        frame_done_d   = 1'b0;
        swap           = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_full_q) begin
                    state_d   = BLANK;
                    index_d   = '0;
                    counter_d = '0;
                    swap      = 1'b1;
                end
            end
            BLANK: begin
                if (counter_q == BLANK_LAST) begin
                    counter_d = '0;
                    state_d   = SHOW;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            SHOW: begin
                if (counter_q == DWELL_LAST) begin
                    counter_d = '0;
                    state_d   = BLANK;
                    if (index_q == IDX_LAST) begin
                        index_d      = '0;
                        frame_done_d = 1'b1;
                        swap         = pending_full_q;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Swap and accept are mutually exclusive: accept needs pending empty, swap needs it full.
        if (swap) begin
            display_d      = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = data_in;
            pending_full_d = 1'b1;
        end
    end

    // NOTE: data registers are reset as well so a mid-scan reset discards stale pending/display contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            index_q        <= '0;
            counter_q      <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            display_q      <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            index_q        <= index_d;
            counter_q      <= counter_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            display_q      <= display_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign nibble = 4'(display_q >> {index_q, 2'b00});

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    logic upper_zero;
    assign upper_zero = (display_q >> {index_q, 2'b00}) == '0;
    assign lz_dark    = (index_q != '0) && upper_zero;
`else
    assign lz_dark = 1'b0;
`endif

    always_comb begin
        hex      = 4'h0;
        blank    = 1'b1;
        digit_en = '0;
        case (state_q)
            BLANK: hex = nibble;
            SHOW: begin
                hex = nibble;
                if (!lz_dark) begin
                    blank    = 1'b0;
                    digit_en = DIGITS'(1) << index_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a frame-level timing model predicts every cycle's outputs,
// a separate monitor compares them against the DUT on the falling edge.
module tb_hex_display_scanner;

    localparam int DIGITS = 4;
    localparam int DWELL  = 4;
    localparam int BLANKC = 2;
    localparam int SLOT   = BLANKC + DWELL;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [3:0]  hex;
    logic        blank;
    logic [3:0]  digit_en;
    logic        frame_done;

    hex_display_scanner #(
        .DIGITS(DIGITS),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANKC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .hex(hex),
        .blank(blank),
        .digit_en(digit_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hex;
        logic       blank;
        logic [3:0] en;
        logic       fd;
        logic       rdy;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: scan start cycle plus frame arithmetic, one pending slot and a display word.
    bit          m_started;
    bit          m_pfull;
    bit          m_last_acc;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    int          m_c;
    int          m_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_pfull    = 1'b0;
        m_last_acc = 1'b0;
        m_pend     = '0;
        m_disp     = '0;
        m_c        = 0;
        m_s        = 0;
    endtask

    function automatic int m_off();
        return (m_c - m_s) % FRAME;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   off, dig;
        bit   lit;
        e.cyc = m_c;
        e.rdy = !m_pfull;
        if (!m_started) begin
            e.hex = 4'h0; e.blank = 1'b1; e.en = 4'h0; e.fd = 1'b0;
        end else begin
            off = m_off();
            dig = off / SLOT;
            lit = (off % SLOT) >= BLANKC;
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
            if (dig != 0 && (m_disp >> (4 * dig)) == 16'h0) lit = 1'b0;
`endif
            e.hex   = m_disp[4*dig +: 4];
            e.en    = lit ? 4'(1 << dig) : 4'h0;
            e.blank = !lit;
            e.fd    = (off == 0) && (m_c != m_s);
        end
        return e;
    endfunction

    // Drive inputs for one edge, advance the model across it, and queue the expected outputs.
    task automatic step(input bit v, input logic [15:0] d);
        bit acc;
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        acc = v && !m_pfull;
        #1;
        m_c++;
        if (!m_started) begin
            if (m_pfull) begin
                m_started = 1'b1;
                m_s       = m_c;
                m_disp    = m_pend;
                m_pfull   = 1'b0;
            end
        end else if (m_off() == 0 && m_pfull) begin
            m_disp  = m_pend;
            m_pfull = 1'b0;
        end
        if (acc) begin
            m_pend  = d;
            m_pfull = 1'b1;
        end
        m_last_acc = acc;
        sb.push_back(model_out());
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("hex@%0d", e.cyc), hex, e.hex);
                check($sformatf("blank@%0d", e.cyc), blank, e.blank);
                check($sformatf("digit_en@%0d", e.cyc), digit_en, e.en);
                check($sformatf("frame_done@%0d", e.cyc), frame_done, e.fd);
                check($sformatf("data_ready@%0d", e.cyc), data_ready, e.rdy);
            end
        end
    end

    initial begin
        bit          cur_v;
        logic [15:0] cur_d;
        bool_found: begin end
        model_reset();

        // Reset held: outputs dark, ready high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_hex", hex, 4'h0);
        check("rst_blank", blank, 1'b1);
        check("rst_digit_en", digit_en, 4'h0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_data_ready", data_ready, 1'b1);
        rst_n = 1'b1;

        // Idle with no transfer: stays dark, no frame_done.
        repeat (100) step(1'b0, 16'h0);

        // Basic scan of 0x1234.
        step(1'b1, 16'h1234);
        repeat (2 * FRAME + 3) step(1'b0, 16'h0);

        // Back-pressure: load 0xAAAA mid-frame, then hold 0xBBBB valid until accepted.
        begin
            int n = 0;
            while (m_off() != 9 && n < 2 * FRAME) begin step(1'b0, 16'h0); n++; end
            check("bp_reach_midframe", m_off(), 9);
        end
        step(1'b1, 16'hAAAA);
        begin
            int n = 0;
            do begin step(1'b1, 16'hBBBB); n++; end while (!m_last_acc && n < 3 * FRAME);
            check("bp_bbbb_accepted", m_last_acc, 1'b1);
        end
        repeat (2 * FRAME + 2) step(1'b0, 16'h0);

        // Wrap-edge accept with pending empty.
        begin
            int n = 0;
            while (!(m_started && !m_pfull && ((m_c + 1 - m_s) % FRAME) == 0) && n < 2 * FRAME) begin
                step(1'b0, 16'h0);
                n++;
            end
            check("wrap_edge_reached", ((m_c + 1 - m_s) % FRAME), 0);
        end
        step(1'b1, 16'h5555);
        repeat (2 * FRAME + 2) step(1'b0, 16'h0);

        // Leading-zero patterns.
        step(1'b1, 16'h0050);
        repeat (2 * FRAME) step(1'b0, 16'h0);
        step(1'b1, 16'h0000);
        repeat (2 * FRAME) step(1'b0, 16'h0);

        // Randomized traffic, valid held until accepted.
        cur_v = 1'b0;
        cur_d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!cur_v || m_last_acc) begin
                cur_v = ($urandom_range(0, 15) == 0);
                cur_d = ($urandom_range(0, 3) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
            end
            step(cur_v, cur_d);
        end
        data_valid = 1'b0;

        // Reset mid-scan during SHOW of digit 2, with a transfer pending.
        step(1'b1, 16'hC3D2);
        begin
            int n = 0;
            while (!(m_started && m_off() / SLOT == 2 && (m_off() % SLOT) >= BLANKC) && n < 3 * FRAME) begin
                step(1'b0, 16'h0);
                n++;
            end
            check("mid_reset_reach_show2", m_off() / SLOT, 2);
        end
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_blank", blank, 1'b1);
        check("mid_rst_digit_en", digit_en, 4'h0);
        check("mid_rst_hex", hex, 4'h0);
        check("mid_rst_data_ready", data_ready, 1'b1);
        check("mid_rst_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2 * FRAME) step(1'b0, 16'h0);

        // Restart after reset with fresh data.
        step(1'b1, 16'h9E0F);
        repeat (FRAME + 2) step(1'b0, 16'h0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
